fetch_seq_ctrl: RTL



---
 rtl/fetch_seq_ctrl.sv | 114 +++++++++++
 1 files changed

// File: rtl/fetch_seq_ctrl.sv
// fetch_seq_ctrl: PC advance/stall/redirect sequencer with outstanding I-cache tracking; FETCH_PERF_CNT_EN adds perf counters
module fetch_seq_ctrl #(
  parameter int OUTSTANDING_MAX = 2,
  parameter int CNT_W = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush_i,
  input  logic [31:0] flush_pc_i,
  input  logic [1:0]  bp_taken_i,
  input  logic [31:0] bp_target_i,
  input  logic        pause_i,
  input  logic        ibuf_full_i,
  input  logic [31:0] pc_i,
  output logic        icache_req_o,
  output logic [31:0] icache_addr_o,
  input  logic        icache_req_ready_i,
  input  logic        icache_resp_valid_i,
  output logic        resp_valid_o,
  output logic        pc_flush_o,
  output logic [31:0] pc_new_pc_o,
  output logic        pc_stall_o,
  output logic [31:0] perf_stall_cnt_o,
  output logic [31:0] perf_drop_cnt_o
);
  typedef enum logic [1:0] {BOOT, RUN, HOLD, FIRE} state_t;
  localparam logic [CNT_W-1:0] OC_MAX = CNT_W'(OUTSTANDING_MAX);
  state_t state, state_n;
  logic [CNT_W-1:0] oc, oc_n, drop, drop_n, drop_sat;
  logic [CNT_W:0] drop_sum;
  logic [31:0] pend_pc, pend_pc_n, tgt;
  logic req_hold, pend_is_flush, pend_is_flush_n;
  logic redir, can_issue, accept, resp_ok;
  assign redir = flush_i | (|bp_taken_i);
  assign tgt = flush_i ? flush_pc_i : bp_target_i;
  assign can_issue = (state == RUN) & !pause_i & !ibuf_full_i & (oc < OC_MAX) & !redir;
  assign icache_req_o = req_hold | can_issue;
  assign icache_addr_o = pc_i;
  assign accept = icache_req_o & icache_req_ready_i;
  // responses with nothing outstanding are ignored entirely
  assign resp_ok = icache_resp_valid_i & (oc != '0);
  assign pc_stall_o = !accept | pc_flush_o;
  assign resp_valid_o = resp_ok & (drop == '0) & !pc_flush_o;
  assign drop_sum = {1'b0, drop} + {1'b0, oc} - (CNT_W+1)'(resp_ok);
  assign drop_sat = drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
  always_comb begin
    state_n = state;
    pend_pc_n = pend_pc;
    pend_is_flush_n = pend_is_flush;
    pc_flush_o = 1'b0;
    pc_new_pc_o = '0;
    oc_n = oc + CNT_W'(accept) - CNT_W'(resp_ok);
    drop_n = drop - CNT_W'(resp_ok & (drop != '0));
    case (state)
      BOOT: state_n = RUN;
      RUN: begin
        if (redir && !req_hold) begin
          pc_flush_o = 1'b1;
          pc_new_pc_o = tgt;
          drop_n = drop_sat;
        end else if (redir) begin
          pend_pc_n = tgt;
          pend_is_flush_n = flush_i;
          state_n = accept ? FIRE : HOLD;
        end
      end
      HOLD: begin
        pend_pc_n = (flush_i || (redir && !pend_is_flush)) ? tgt : pend_pc;
        pend_is_flush_n = pend_is_flush | flush_i;
        state_n = accept ? FIRE : HOLD;
      end
      FIRE: begin
        pc_flush_o = 1'b1;
        pc_new_pc_o = flush_i ? flush_pc_i : pend_pc;
        drop_n = drop_sat;
        state_n = RUN;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= BOOT;
      oc <= '0;
      drop <= '0;
      req_hold <= 1'b0;
      pend_pc <= '0;
      pend_is_flush <= 1'b0;
    end else begin
      state <= state_n;
      oc <= oc_n;
      drop <= drop_n;
      req_hold <= icache_req_o & !icache_req_ready_i;
      pend_pc <= pend_pc_n;
      pend_is_flush <= pend_is_flush_n;
    end
  end
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_cnt, drop_cnt;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
      drop_cnt <= '0;
    end else begin
      stall_cnt <= stall_cnt + 32'((state == RUN) & pc_stall_o & !pc_flush_o);
      drop_cnt <= drop_cnt + 32'(resp_ok & !resp_valid_o);
    end
  end
  assign perf_stall_cnt_o = stall_cnt;
  assign perf_drop_cnt_o = drop_cnt;
`else
  assign perf_stall_cnt_o = '0;
  assign perf_drop_cnt_o = '0;
`endif
endmodule
